// File: rtl/pattern_gen_pkg.sv
// rtl/pattern_gen_pkg.sv - shared mode and state encodings for the pattern generator
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;
  localparam logic [1:0] MODE_WALK = 2'd3;

  // LFSR locks up on zero and walking-one needs a set bit, so a zero seed becomes 1.
  function automatic logic seed_needs_fixup(input logic [1:0] mode);
    return (mode == MODE_LFSR) || (mode == MODE_WALK);
  endfunction

endpackage

// File: rtl/pattern_gen_next.sv
// rtl/pattern_gen_next.sv - combinational next-word function for each pattern mode
module pattern_gen_next
  import pattern_gen_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 16'hB400
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] next_data
);

  always_comb begin
    next_data = data;
    case (mode)
      MODE_UP:   next_data = data + step;
      MODE_DOWN: next_data = data - step;
      MODE_LFSR: next_data = (data >> 1) ^ (data[0] ? LFSR_TAPS : '0);
      MODE_WALK: next_data = {data[WIDTH-2:0], data[WIDTH-1]};
      default:   next_data = data;
    endcase
  end

endmodule

// File: rtl/pattern_gen.sv
// rtl/pattern_gen.sv - handshaked test-pattern generator with burst and continuous modes
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               BURST_W   = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 16'hB400
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   seed,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   step,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               abort,
  input  logic               ready,
  output logic [WIDTH-1:0]   data,
  output logic               valid,
  output logic               busy,
  output logic               done
);

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         mode_q;
  logic [WIDTH-1:0]   step_q;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] count_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   next_data;
  logic               xfer;
  logic               last_xfer;

  pattern_gen_next #(
    .WIDTH     (WIDTH),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_next (
    .data      (data_q),
    .mode      (mode_q),
    .step      (step_q),
    .next_data (next_data)
  );

  assign xfer      = (state == ST_RUN) && ready;
  // burst_q == 0 means continuous, so only a nonzero length can end the burst
  assign last_xfer = xfer && (burst_q != '0) && (count_q == burst_q - BURST_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (last_xfer) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    data  = data_q;
    valid = (state == ST_RUN);
    busy  = (state == ST_RUN);
    done  = (state == ST_DONE);
  end

  // Load uses the live mode input so the zero-seed fixup matches the burst about to start.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if ((state == ST_IDLE) && load) begin
      if ((seed == '0) && seed_needs_fixup(mode)) begin
        data_q <= WIDTH'(1);
      end else begin
        data_q <= seed;
      end
    end else if (xfer) begin
      data_q <= next_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_UP;
      step_q  <= '0;
      burst_q <= '0;
      count_q <= '0;
    end else if ((state == ST_IDLE) && start) begin
      mode_q  <= mode;
      step_q  <= step;
      burst_q <= burst_len;
      count_q <= '0;
    end else if (xfer) begin
      count_q <= count_q + BURST_W'(1);
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// tb/tb_pattern_gen.sv - scoreboard bench for pattern_gen with randomized bursts and backpressure
module tb_pattern_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] seed = '0;
  logic        start = 1'b0;
  logic [1:0]  mode = '0;
  logic [15:0] step = '0;
  logic [7:0]  burst_len = '0;
  logic        abort = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] data;
  logic        valid;
  logic        busy;
  logic        done;

  int          n_vec = 0;
  int          n_err = 0;
  bit          rnd_ready = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] model_data = '0;

  pattern_gen #(.WIDTH(16), .BURST_W(8), .LFSR_TAPS(16'hB400)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .seed      (seed),
    .start     (start),
    .mode      (mode),
    .step      (step),
    .burst_len (burst_len),
    .abort     (abort),
    .ready     (ready),
    .data      (data),
    .valid     (valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_next(input logic [15:0] d, input int m, input logic [15:0] s);
    int unsigned dv;
    int unsigned sv;
    int unsigned r;
    dv = d;
    sv = s;
    case (m)
      0: r = (dv + sv) % 65536;
      1: r = (dv + 65536 - sv) % 65536;
      2: r = (dv / 2) ^ (((dv % 2) == 1) ? 32'hB400 : 32'h0);
      default: r = ((dv * 2) % 65536) + (dv / 32768);
    endcase
    return r[15:0];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) ready = 1'($urandom_range(0, 1));
  endtask

  always @(negedge clk) begin
    if (!reset && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got 0x%04h, expected no transfer", data);
      end else begin
        chk("sb_word", data, exp_q.pop_front());
      end
    end
  end

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    chk({name, "_done"}, {15'b0, seen}, 16'h0001);
    if (seen) begin
      chk({name, "_data_after"}, data, model_data);
      chk({name, "_busy"}, {15'b0, busy}, 16'h0000);
      chk({name, "_valid"}, {15'b0, valid}, 16'h0000);
      chk({name, "_pending"}, 16'(exp_q.size()), 16'h0000);
      tick();
      chk({name, "_done_width"}, {15'b0, done}, 16'h0000);
    end
  endtask

  task automatic issue(input bit do_load, input logic [15:0] s, input int m,
                       input logic [15:0] st, input int len);
    if (do_load) begin
      load = 1'b1;
      seed = s;
      model_data = (s == 16'h0 && m >= 2) ? 16'h0001 : s;
    end
    start = 1'b1;
    mode = m[1:0];
    step = st;
    burst_len = len[7:0];
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(model_data);
      model_data = ref_next(model_data, m, st);
    end
    tick();
    load = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_burst(input string name, input bit do_load, input logic [15:0] s,
                           input int m, input logic [15:0] st, input int len);
    issue(do_load, s, m, st, len);
    wait_done(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("rst_data", data, 16'h0000);
    chk("rst_valid", {15'b0, valid}, 16'h0000);
    chk("rst_busy", {15'b0, busy}, 16'h0000);
    chk("rst_done", {15'b0, done}, 16'h0000);
    reset = 1'b0;
    ready = 1'b1;
    tick();

    run_burst("t1_up", 1'b1, 16'h0000, 0, 16'h0003, 4);
    chk("t1_end", data, 16'h000C);

    run_burst("t2_wrap_up", 1'b1, 16'hFFFE, 0, 16'h0001, 3);
    chk("t2_up_end", data, 16'h0001);
    run_burst("t2_wrap_dn", 1'b1, 16'h0002, 1, 16'h0002, 3);
    chk("t2_dn_end", data, 16'hFFFC);

    run_burst("t3_lfsr", 1'b1, 16'h0001, 2, 16'h0000, 4);
    chk("t3_end", data, 16'h1680);
    load = 1'b1; seed = 16'h0000; mode = 2'd2;
    tick();
    load = 1'b0;
    chk("t3_zero_seed", data, 16'h0001);
    model_data = 16'h0001;

    // backpressure: ready 1,0,0,1,1 after the burst starts
    issue(1'b1, 16'h0010, 0, 16'h0001, 3);
    ready = 1'b1; tick();
    ready = 1'b0; chk("t4_hold0", data, 16'h0011); tick();
    chk("t4_hold1", data, 16'h0011);
    chk("t4_nodone", {15'b0, done}, 16'h0000); tick();
    chk("t4_hold2", data, 16'h0011);
    ready = 1'b1; tick();
    chk("t4_nodone2", {15'b0, done}, 16'h0000); tick();
    wait_done("t4_bp");
    chk("t4_end", data, 16'h0013);

    // walking one; a start/load during RUN must be ignored
    issue(1'b1, 16'h0000, 3, 16'h0000, 17);
    tick();
    start = 1'b1; load = 1'b1; mode = 2'd0; step = 16'h0005; seed = 16'h1234;
    tick();
    start = 1'b0; load = 1'b0;
    wait_done("t5_walk");
    chk("t5_end", data, 16'h0002);

    // randomized bursts with random backpressure
    rnd_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      int m;
      int len;
      bit ld;
      logic [15:0] s;
      m = $urandom_range(0, 3);
      len = $urandom_range(1, 20);
      ld = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      run_burst("rnd", ld, s, m, 16'($urandom), len);
    end
    rnd_ready = 1'b0;

    // abort on the fifth transfer of a continuous burst
    ready = 1'b1;
    issue(1'b1, 16'h0100, 0, 16'h0001, 0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(model_data);
      model_data = ref_next(model_data, 0, 16'h0001);
    end
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort_valid", {15'b0, valid}, 16'h0000);
    chk("t6_abort_busy", {15'b0, busy}, 16'h0000);
    chk("t6_abort_done", {15'b0, done}, 16'h0000);
    chk("t6_abort_data", data, 16'h0105);
    tick();
    chk("t6_abort_nodone", {15'b0, done}, 16'h0000);
    chk("t6_abort_pending", 16'(exp_q.size()), 16'h0000);

    // reset in the middle of a stalled continuous burst
    ready = 1'b0;
    issue(1'b1, 16'h0200, 0, 16'h0001, 0);
    tick();
    chk("t6_run_valid", {15'b0, valid}, 16'h0001);
    chk("t6_run_hold", data, 16'h0200);
    reset = 1'b1;
    tick();
    chk("t6_rst_data", data, 16'h0000);
    chk("t6_rst_valid", {15'b0, valid}, 16'h0000);
    chk("t6_rst_busy", {15'b0, busy}, 16'h0000);
    chk("t6_rst_done", {15'b0, done}, 16'h0000);
    reset = 1'b0;
    tick();
    chk("t6_post_done", {15'b0, done}, 16'h0000);
    chk("t6_post_busy", {15'b0, busy}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
Parametrised test-pattern data generator, the successor to the fixed 16-bit incrementing data generator. Produces a stream of WIDTH-bit words with a valid/ready handshake. Supports four modes: up-count by step, down-count by step, Galois LFSR, and walking-one. Supports a programmable burst length or continuous mode. Sits in front of DUT data paths in benches and in on-chip self-test, feeding sinks that may apply backpressure.

Parameters:
WIDTH, 16, data word width (>=2)
BURST_W, 8, width of the burst length counter
LFSR_TAPS, 16'hB400, Galois feedback mask, WIDTH bits

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
load  in  1  IDLE only: data register <= seed
seed  in  WIDTH  load value
start  in  1  IDLE only: begin burst
mode  in  2  0 up, 1 down, 2 LFSR, 3 walking-one; latched at start
step  in  WIDTH  increment/decrement amount; latched at start
burst_len  in  BURST_W  words per burst; 0 = continuous; latched at start
abort  in  1  RUN: terminate burst immediately
ready  in  1  sink accepts word
data  out  WIDTH  current word
valid  out  1  data is a valid word
busy  out  1  high in RUN
done  out  1  one-cycle pulse after the final word of a finite burst

Behaviour:
- One clock (clk); reset is synchronous and active-high. Reset values: data=0, valid=0, busy=0, done=0, transfer count=0, state IDLE.
- States: IDLE, RUN, DONE.
- IDLE, load=1: data <= seed next cycle. Zero-seed fixup: if seed==0 and the mode input is 2 or 3, data <= 1. This prevents LFSR lockup and keeps a one-hot word in walking-one mode.
- IDLE, start=1: go to RUN. Latch mode, step and burst_len; clear count. valid=1 from the next cycle with the current data.
- load and start in the same cycle: both take effect; the first word is the (fixed-up) seed.
- Without a new load, data continues from its last value across bursts.
- RUN: valid=1, busy=1. A transfer occurs on valid&ready. On a transfer, data <= next(data) and count++. If ready=0, data is held stable.
- Finite burst: if burst_len!=0 and the transfer is word number burst_len (count==burst_len-1), go to DONE. valid falls the next cycle. data still advances once, so it holds the word after the last one sent.
- Continuous burst: burst_len==0 runs until abort.
- abort in RUN: go to IDLE next cycle; valid=0; done is not pulsed. A handshake in the abort cycle still counts and still advances data.
- DONE: done=1, valid=0, busy=0 for exactly one cycle, then IDLE.
- start, load and input changes are ignored outside IDLE.
- next() by latched mode, all arithmetic mod 2^WIDTH:
  - up: data+step
  - down: data-step
  - LFSR: (data>>1) ^ (data[0] ? LFSR_TAPS : 0)
  - walking-one: rotate left by 1
- Reset mid-burst returns all state to reset values within one cycle; no done is issued.

Decomposition:
- pattern_gen_pkg holds: mode constants (MODE_UP, MODE_DOWN, MODE_LFSR, MODE_WALK) and state encoding (ST_IDLE, ST_RUN, ST_DONE).
- One combinational sub-module, pattern_gen_next: inputs data, mode, step; output next word; parametrised by WIDTH and LFSR_TAPS.
- The top level contains the FSM, the data register, the burst counter and the handshake logic.

Test Plan:
1. Up count: load seed 0x0000, mode 0, step 3, burst 4, ready=1 -> valid for 4 cycles with data 0x0000,0x0003,0x0006,0x0009; done pulse one cycle later; data then 0x000C; busy falls.
2. Wrap-around: seed 0xFFFE, up, step 1, burst 3 -> 0xFFFE,0xFFFF,0x0000. Then seed 0x0002, down, step 2, burst 3 -> 0x0002,0x0000,0xFFFE.
3. LFSR: seed 0x0001, mode 2, burst 4 -> 0x0001,0xB400,0x5A00,0x2D00. Also: seed 0x0000 with mode 2 loads 0x0001.
4. Backpressure: up, step 1, seed 0x0010, burst 3, ready pattern 1,0,0,1,1 -> data stays 0x0011 while ready=0; exactly 3 transfers (0x0010,0x0011,0x0012); done only after the third.
5. Walking-one: seed 0, mode 3, burst 17 -> 0x0001,0x0002,...,0x8000,0x0001. Also: start during RUN with different mode/step changes nothing.
6. Abort and reset: continuous up burst, abort after 5 transfers -> valid=0 next cycle, no done, data=seed+5. Then restart and assert reset mid-burst -> next cycle data=0, valid=0, busy=0, done=0.
